// File: rtl/rounder_arbiter_if.sv
// rounder_arbiter_if
//   Groups the requester-side and result-side handshakes of rounder_arbiter.
//   Parameters:
//     NUM_REQ : number of requesters
//     ID_W    : requester id width (clog2(NUM_REQ))
//   Signals:
//     req_valid [NUM_REQ]     per-requester valid
//     req_data  [NUM_REQ*32]  requester i at bits [32*i+31:32*i]
//     req_ready [NUM_REQ]     one-hot grant, or all zero
//     out_valid / out_data / out_id / out_ready   result handshake
//   Modports:
//     slave  : the arbiter side
//     master : the producer/consumer side (testbench or surrounding logic)
interface rounder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_ready;

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_id
    );

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_id
    );
endinterface

// File: rtl/rounder_arbiter.sv
// rounder_arbiter
//   Round-robin arbiter in front of a shared 2-stage rounding pipeline.
//   One word per cycle is accepted from NUM_REQ requesters; each result is
//   returned with the id of the requester that issued it.
//   Ports:
//     clk             in   rising-edge clock
//     rst_n           in   asynchronous active-low reset
//     bus             slave modport of rounder_arbiter_if (request/result handshakes)
//     stat_accept_cnt out  saturating count of accepted words      (ROUNDER_ARB_STATS_EN only)
//     stat_stall_cnt  out  saturating count of out_valid && !out_ready cycles (ROUNDER_ARB_STATS_EN only)
//   Optional feature macro: ROUNDER_ARB_STATS_EN
module rounder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ROUNDER_ARB_STATS_EN
    output logic [15:0] stat_accept_cnt,
    output logic [15:0] stat_stall_cnt,
`endif
    rounder_arbiter_if.slave bus
);

    localparam logic [30:0] HALF_RANGE = 31'h4000_0000;

    // R(x): sign passes through; magnitudes at or above 2^30 are offset and
    // rounded half-up, smaller magnitudes are simply halved.
    function automatic logic [31:0] round_word(input logic [31:0] x);
        logic [30:0] m;
        logic [30:0] f;
        logic [30:0] y;
        m = x[30:0];
        f = m - HALF_RANGE;
        if (m >= HALF_RANGE) begin
            y = (f >> 1) + {30'd0, f[0]};
        end else begin
            y = m >> 1;
        end
        return {x[31], y};
    endfunction

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [ID_W:0]   cand;
    logic [31:0]     win_data;

    logic            v1;
    logic [31:0]     x1;
    logic [ID_W-1:0] id1;
    logic            v2;
    logic [31:0]     d2;
    logic [ID_W-1:0] id2;

    logic            adv2;
    logic            s2_free;
    logic            move12;
    logic            s1_free;
    logic            xfer;

    // Circular priority search starting at ptr; cand carries one extra bit so
    // the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = bus.req_data[32*i +: 32];
            end
        end
    end

    // S1 may load in the same cycle it hands its word to a draining S2, which
    // keeps a full pipeline moving at one word per cycle.
    assign adv2    = v2 && bus.out_ready;
    assign s2_free = !v2 || adv2;
    assign move12  = v1 && s2_free;
    assign s1_free = !v1 || move12;
    // rst_n gates the grant so req_ready stays low throughout reset.
    assign xfer    = rst_n && found && s1_free;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            if (winner == ID_W'(NUM_REQ-1)) begin
                ptr <= '0;
            end else begin
                ptr <= winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            x1  <= '0;
            id1 <= '0;
        end else if (xfer) begin
            v1  <= 1'b1;
            x1  <= win_data;
            id1 <= winner;
        end else if (move12) begin
            v1  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            d2  <= '0;
            id2 <= '0;
        end else if (move12) begin
            v2  <= 1'b1;
            d2  <= round_word(x1);
            id2 <= id1;
        end else if (adv2) begin
            v2  <= 1'b0;
        end
    end

    assign bus.out_valid = v2;
    assign bus.out_data  = d2;
    assign bus.out_id    = id2;

`ifdef ROUNDER_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept_cnt <= '0;
        end else if (xfer && (stat_accept_cnt != 16'hFFFF)) begin
            stat_accept_cnt <= stat_accept_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
        end else if (v2 && !bus.out_ready && (stat_stall_cnt != 16'hFFFF)) begin
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rounder_arbiter.sv
module tb_rounder_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef ROUNDER_ARB_STATS_EN
    logic [15:0] stat_accept_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    rounder_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    rounder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef ROUNDER_ARB_STATS_EN
        .stat_accept_cnt (stat_accept_cnt),
        .stat_stall_cnt  (stat_stall_cnt),
`endif
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = {4{32'h1234_5678}};
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data);
        end
        checks++;
        if (bus.out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_id: got %0d expected 0", bus.out_id);
        end
`ifdef ROUNDER_ARB_STATS_EN
        checks++;
        if (stat_accept_cnt !== 16'h0 || stat_stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_stats: got %h/%h expected 0000/0000", stat_accept_cnt, stat_stall_cnt);
        end
`endif
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int          lane_tab [5] = '{0, 2, 1, 3, 0};
        logic [31:0] din_tab  [5] = '{32'h4000_0003, 32'h0000_0006, 32'h8000_0005,
                                      32'hC000_0000, 32'h7FFF_FFFF};
        logic [31:0] dout_tab [5] = '{32'h0000_0002, 32'h0000_0003, 32'h8000_0002,
                                      32'h8000_0000, 32'h2000_0000};
        logic [3:0]  exp_rdy;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            exp_rdy = 4'b0001 << lane_tab[v];
            bus.req_data = '0;
            bus.req_data[32*lane_tab[v] +: 32] = din_tab[v];
            bus.req_valid = exp_rdy;
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL single_grant[%0d]: got %b expected %b", v, bus.req_ready, exp_rdy);
            end
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_latency_early[%0d]: out_valid got %b expected 0", v, bus.out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_valid[%0d]: got %b expected 1", v, bus.out_valid);
            end
            checks++;
            if (bus.out_data !== dout_tab[v] || bus.out_id !== 2'(lane_tab[v])) begin
                errors++;
                $display("FAIL single_result[%0d]: got %h id %0d expected %h id %0d",
                         v, bus.out_data, bus.out_id, dout_tab[v], lane_tab[v]);
            end
        end
        @(negedge clk);
        drain();
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_rdy;
        logic [31:0] exp_d;
        logic [1:0]  exp_id;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_data[32*i +: 32] = 32'((i + 1) * 16);
        end
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy);
            end
            if (k >= 2) begin
                exp_id = 2'((k - 2) % 4);
                exp_d  = 32'((((k - 2) % 4) + 1) * 8);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_data !== exp_d) begin
                    errors++;
                    $display("FAIL fair_out[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                             k, bus.out_valid, bus.out_id, bus.out_data, exp_id, exp_d);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_grant_skip();
        logic [3:0] exp_rdy;
        apply_reset();
        bus.req_data  = '0;
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL skip_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy);
            end
            @(posedge clk);
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int         idx;
        int         ocnt;
        logic       xf;
        logic [31:0] exp_d;
        apply_reset();
        idx  = 0;
        ocnt = 0;
        bus.req_data  = '0;
        bus.req_data[31:0] = 32'h0000_0100;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 40 && ocnt < 6; c++) begin
            bus.out_ready = (c >= 7);
            #1;
            if (c >= 2 && c <= 6) begin
                checks++;
                if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
                    bus.out_data !== 32'h0000_0080 || bus.out_id !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h id=%0d expected rdy=0000 v=1 d=00000080 id=0",
                             c, bus.req_ready, bus.out_valid, bus.out_data, bus.out_id);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_d = 32'h80 * (ocnt + 1);
                checks++;
                if (bus.out_data !== exp_d || bus.out_id !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h id %0d expected %h id 0",
                             ocnt, bus.out_data, bus.out_id, exp_d);
                end
                ocnt++;
            end
            xf = bus.req_valid[0] && bus.req_ready[0];
            @(posedge clk);
            @(negedge clk);
            if (xf) begin
                idx++;
                if (idx < 6) begin
                    bus.req_data[31:0] = 32'h100 * (idx + 1);
                end else begin
                    bus.req_valid = '0;
                end
            end
        end
        #1;
        checks++;
        if (ocnt !== 6 || idx !== 6) begin
            errors++;
            $display("FAIL bp_count: got out=%0d in=%0d expected 6/6", ocnt, idx);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid got %b expected 0", bus.out_valid);
        end
`ifdef ROUNDER_ARB_STATS_EN
        checks++;
        if (stat_accept_cnt !== 16'd6 || stat_stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_stats: got accept=%0d stall=%0d expected 6/5", stat_accept_cnt, stat_stall_cnt);
        end
`endif
        @(negedge clk);
        drain();
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        bus.req_data  = '0;
        bus.req_data[63:32] = 32'h0000_0010;
        bus.req_data[95:64] = 32'h0000_0020;
        bus.req_valid = 4'b0110;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_full: got v=%b rdy=%b expected v=1 rdy=0000", bus.out_valid, bus.req_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear: got v=%b rdy=%b d=%h expected v=0 rdy=0000 d=00000000",
                     bus.out_valid, bus.req_ready, bus.out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first_grant: got %b expected 0001", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

`ifdef ROUNDER_ARB_STATS_EN
    task automatic test_saturation();
        apply_reset();
        bus.req_valid = 4'b0001;
        bus.out_ready = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stat_accept_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h expected FFFF", stat_accept_cnt);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stat_accept_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h expected FFFF", stat_accept_cnt);
        end
        drain();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_grant_skip();
        test_backpressure();
        test_reset_midstream();
`ifdef ROUNDER_ARB_STATS_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rounder_arbiter.md
# rounder_arbiter

Shares a single rounding datapath between NUM_REQ producers in the JPEG decoder back end, such as parallel IDCT lanes that each emit 32-bit sign-magnitude fixed-point words.
- Round-robin arbitration accepts one word per cycle through valid/ready handshakes.
- Each accepted word goes through a 2-stage registered pipeline that applies the rounding function R.
- The result is returned with the id of the requester that issued it.
- The output honours downstream backpressure without losing data.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*32  requester i occupies bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot grant (or all zero); a word transfers when req_valid[i] && req_ready[i].
- out_valid  out  1  result valid.
- out_data  out  32  R(x) of the accepted word.
- out_id  out  ID_W  index of the requester that issued the word.
- out_ready  in  1  downstream accept.

## Operation
Rounding function R(x), for x[31:0]:
- s = x[31] (sign, passed through unchanged).
- m = x[30:0].
- If m >= 2^30: f = m - 2^30, y = {s, (f>>1) + f[0]}, truncated to 31 bits.
- Otherwise: y = {s, m>>1}.
- All arithmetic is unsigned, 31 bits wide.

Arbitration:
- Round-robin pointer ptr (ID_W bits), reset to 0.
- Search req_valid starting at index ptr, upward, modulo NUM_REQ; the first set bit wins.
- Only the winner's req_ready is asserted, and only when stage 1 can load. req_ready is combinational from req_valid and pipeline state.
- On a transfer, ptr <= (winner+1) mod NUM_REQ. If nothing transfers, ptr holds.

Pipeline:
- Stage S1: registers x, id and v1. It loads on a transfer.
- Stage S2: registers R(x), id and v2. It drives out_data, out_id and out_valid = v2.
- adv2 = v2 && out_ready; S2 can load when !v2 || adv2.
- S1 moves into S2 when v1 && (!v2 || adv2); S1 can load when !v1 || (that move occurs).
- If S1 empties without being refilled, v1 <= 0. If S2 drains without a refill, v2 <= 0.
- out_data and out_id stay stable while out_valid && !out_ready.

## Timing
- Reset values: req_ready=0 while rst_n is low; out_valid=0, out_data=0, out_id=0, ptr=0, v1=v2=0.
- Reset asserted mid-operation discards all in-flight words immediately (asynchronous); no partial output.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+2.
- Throughput: 1 word/cycle with out_ready held at 1.
- Full: v1=v2=1 and out_ready=0 gives req_ready=0 on all lanes.
- Simultaneous drain and accept (full pipeline, out_ready=1) loads a new word the same cycle, with no bubble.
- Deasserting req_valid without a transfer is legal; the grant moves to the next requester.
- ptr wraps from NUM_REQ-1 to 0.

## Configuration
ROUNDER_ARB_STATS_EN:
- Defined: adds output ports stat_accept_cnt[15:0] and stat_stall_cnt[15:0].
  - stat_accept_cnt counts transfers.
  - stat_stall_cnt counts cycles with out_valid && !out_ready.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single word: lane 0 sends 0x40000003, out_ready=1 → after 2 cycles out_valid=1, out_data=0x00000002, out_id=0. Lane 2 sends 0x00000006 → 0x00000003, out_id=2.
- Sign and carry: 0x80000005 → 0x80000002. 0xC0000000 → 0x80000000. 0x7FFFFFFF → 0x20000000.
- Fairness: all 4 lanes valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1,…; one word per cycle after a 2-cycle fill.
- Backpressure: stream 6 words, hold out_ready=0 for 5 cycles.
  - Response: req_ready=0 once v1=v2=1; out_data is stable; no word is lost or duplicated; order is preserved after release.
  - With ROUNDER_ARB_STATS_EN: stat_stall_cnt=5 and stat_accept_cnt=6.
- Reset mid-stream: pull rst_n low with v1=v2=1 → out_valid=0 and req_ready=0 immediately. After release, the first grant goes to lane 0 (ptr=0).
- Saturation (ROUNDER_ARB_STATS_EN): 70000 transfers → stat_accept_cnt=0xFFFF, and it holds.
